ag6502_dma_ctrl: RTL and testbench

Bus-master DMA controller and bus arbiter for the ag6502 system bus. It takes the memory bus away from the CPU by dropping `rdy`, and waits until the CPU is halted on a read cycle. It then runs memory-to-memory copy or fill transfers, and hands the bus back either in bursts or when the transfer is complete. It sits between the CPU (`ab`/`read`/`db_out`/`rdy`) and the memory/peripheral bus, is configured through a small register port, and raises an active-low interrupt for the CPU `irq` pin.

---
 rtl/ag6502_dma_ctrl_if.sv | 22 ++
 rtl/ag6502_dma_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ag6502_dma_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ag6502_dma_ctrl_if.sv
// CPU-side and memory-side bus bundle for the ag6502 DMA controller.
// The master modport is the controller's view; slave is the CPU/memory side.
interface ag6502_dma_ctrl_if;
    logic [15:0] cpu_ab;
    logic        cpu_read;
    logic [7:0]  cpu_db_out;
    logic        cpu_rdy;
    logic [15:0] mem_ab;
    logic        mem_read;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        input  cpu_ab, cpu_read, cpu_db_out, mem_rdata,
        output cpu_rdy, mem_ab, mem_read, mem_wdata
    );

    modport slave (
        output cpu_ab, cpu_read, cpu_db_out, mem_rdata,
        input  cpu_rdy, mem_ab, mem_read, mem_wdata
    );
endinterface

// File: rtl/ag6502_dma_ctrl.sv
// Bus-master DMA controller: halts the CPU via rdy, performs copy/fill transfers
// in bursts of up to BURST bytes, and signals completion on an active-low irq.
module ag6502_dma_ctrl #(
    parameter int BURST = 16
) (
    input  logic                  baseclk,
    input  logic                  rst,
    input  logic                  cyc,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_addr,
    input  logic [7:0]            cfg_wdata,
    output logic [7:0]            cfg_rdata,
    output logic                  busy,
    output logic                  irq_n,
    output logic [2:0]            dbg_state,
    ag6502_dma_ctrl_if.master     bus
);
    localparam int BC_W = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       src, dst, len, cnt;
    logic [BC_W-1:0]   bc;
    logic [7:0]        buf_q;
    logic              done, ie, fill, abort_p, have_buf;
    logic              finish;
    logic              ctrl_wr, start_req, abort_now, bc_last;

    // Handshake: cpu_rdy low asks the CPU to halt; the bus is only taken on a cyc
    // where the CPU is seen reading, since a 6502 write cycle cannot be stretched.
    assign ctrl_wr   = cfg_we && (cfg_addr == 3'd6);
    assign start_req = ctrl_wr && cfg_wdata[0] && (state_q == S_IDLE);
    assign abort_now = abort_p || (ctrl_wr && cfg_wdata[3]);
    assign bc_last   = (bc == BC_W'(BURST - 1));

    always_comb begin
        state_d       = state_q;
        finish        = 1'b0;
        bus.cpu_rdy   = 1'b0;
        bus.mem_ab    = bus.cpu_ab;
        bus.mem_read  = bus.cpu_read;
        bus.mem_wdata = bus.cpu_db_out;
        case (state_q)
            S_IDLE: begin
                bus.cpu_rdy = 1'b1;
                if (start_req && (len != 16'd0)) state_d = S_REQ;
            end
            S_REQ: begin
                if (cyc) begin
                    if (abort_now) begin
                        state_d = S_IDLE;
                        finish  = 1'b1;
                    end else if (bus.cpu_read) begin
                        // A fill resuming after a gap already holds its byte.
                        state_d = (fill && have_buf) ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                bus.mem_ab   = src;
                bus.mem_read = 1'b1;
                if (cyc) state_d = S_WR;
            end
            S_WR: begin
                bus.mem_ab    = dst;
                bus.mem_read  = 1'b0;
                bus.mem_wdata = buf_q;
                if (cyc) begin
                    if ((cnt == 16'd1) || abort_now) begin
                        state_d = S_IDLE;
                        finish  = 1'b1;
                    end else if (bc_last) begin
                        state_d = S_GAP;
                    end else if (fill) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_GAP: begin
                bus.cpu_rdy = 1'b1;
                if (cyc) begin
                    state_d = abort_now ? S_IDLE : S_REQ;
                    finish  = abort_now;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge baseclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            cnt      <= '0;
            bc       <= '0;
            buf_q    <= '0;
            done     <= 1'b0;
            ie       <= 1'b0;
            fill     <= 1'b0;
            abort_p  <= 1'b0;
            have_buf <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_we && (state_q == S_IDLE)) begin
                case (cfg_addr)
                    3'd0:    src[7:0]  <= cfg_wdata;
                    3'd1:    src[15:8] <= cfg_wdata;
                    3'd2:    dst[7:0]  <= cfg_wdata;
                    3'd3:    dst[15:8] <= cfg_wdata;
                    3'd4:    len[7:0]  <= cfg_wdata;
                    3'd5:    len[15:8] <= cfg_wdata;
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                done <= 1'b0;
                if (start_req) begin
                    fill     <= cfg_wdata[1];
                    ie       <= cfg_wdata[2];
                    cnt      <= len;
                    bc       <= '0;
                    have_buf <= 1'b0;
                    if (len == 16'd0) done <= 1'b1;
                end else if ((state_q != S_IDLE) && cfg_wdata[3]) begin
                    abort_p <= 1'b1;
                end
            end
            if (cyc) begin
                case (state_q)
                    S_RD: begin
                        buf_q    <= bus.mem_rdata;
                        src      <= src + 16'd1;
                        have_buf <= 1'b1;
                    end
                    S_WR: begin
                        dst <= dst + 16'd1;
                        cnt <= cnt - 16'd1;
                        bc  <= (state_d == S_GAP) ? '0 : bc + BC_W'(1);
                    end
                    default: ;
                endcase
            end
            // Completion wins over the done-clear of a coinciding CTRL write.
            if (finish) begin
                done    <= 1'b1;
                abort_p <= 1'b0;
            end
        end
    end

    always_comb begin
        case (cfg_addr)
            3'd0:    cfg_rdata = src[7:0];
            3'd1:    cfg_rdata = src[15:8];
            3'd2:    cfg_rdata = dst[7:0];
            3'd3:    cfg_rdata = dst[15:8];
            3'd4:    cfg_rdata = len[7:0];
            3'd5:    cfg_rdata = len[15:8];
            3'd6:    cfg_rdata = {4'b0, abort_p, ie, fill, busy};
            default: cfg_rdata = {busy, done, 6'b0};
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign irq_n     = ~(done & ie);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_ag6502_dma_ctrl.sv
// Directed bench for ag6502_dma_ctrl: register table, bus-sequence scoreboard,
// burst gaps, CPU-write stall, zero length, abort and mid-transfer reset.
module tb_ag6502_dma_ctrl;
    localparam logic [2:0] ST_RD = 3'd2;
    localparam logic [2:0] ST_WR = 3'd3;

    logic       baseclk = 1'b0;
    logic       rst, cyc, cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata, cfg_rdata;
    logic       busy, irq_n;
    logic [2:0] dbg_state;

    ag6502_dma_ctrl_if bus();

    ag6502_dma_ctrl #(.BURST(16)) dut (
        .baseclk(baseclk), .rst(rst), .cyc(cyc), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .busy(busy), .irq_n(irq_n), .dbg_state(dbg_state), .bus(bus)
    );

    always #5 baseclk = ~baseclk;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign bus.mem_rdata = mem_f(bus.mem_ab);

    int          checks = 0;
    int          errors = 0;
    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    int          obs_rd = 0;
    int          wr_count = 0;
    int          gap_log[$];

    // Bus monitor: records every DMA-owned cycle and every CPU gap cycle.
    always @(negedge baseclk) begin
        if (!rst && cyc) begin
            if (dbg_state == ST_RD || dbg_state == ST_WR) begin
                obs_q.push_back({bus.mem_read, bus.mem_ab, bus.mem_read ? 8'h00 : bus.mem_wdata});
                if (dbg_state == ST_WR) wr_count++;
            end else if (busy && bus.cpu_rdy) begin
                gap_log.push_back(wr_count);
            end
        end
    end

    typedef struct {
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;
    reg_vec_t vecs[7];

    task automatic tick();
        @(posedge baseclk);
        #1;
    endtask

    task automatic bus_cycle();
        cyc = 1'b1;
        tick();
        cyc = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        cfg_read(a, d);
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        cfg_write(3'd0, s[7:0]);
        cfg_write(3'd1, s[15:8]);
        cfg_write(3'd2, d[7:0]);
        cfg_write(3'd3, d[15:8]);
        cfg_write(3'd4, l[7:0]);
        cfg_write(3'd5, l[15:8]);
    endtask

    task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, s + 16'(i), 8'h00});
            exp_q.push_back({1'b0, d + 16'(i), mem_f(s + 16'(i))});
        end
    endtask

    task automatic run_xfer(input string name, output int n);
        n = 0;
        while (busy && n < 300) begin
            bus_cycle();
            n++;
        end
        check({name, "_timeout"}, 32'(busy), 32'(0));
    endtask

    task automatic compare_bus(input string name);
        while (exp_q.size() > 0) begin
            logic [24:0] e;
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                check(name, 32'(obs_q[obs_rd]), 32'(e));
                obs_rd++;
            end else begin
                check({name, "_missing"}, 32'(0), 32'(e));
            end
        end
        check({name, "_extra"}, 32'(obs_q.size() - obs_rd), 32'(0));
        obs_rd = obs_q.size();
    endtask

    initial begin
        int n, wbase, gbase, g0, g1;

        vecs[0] = '{3'd0, 8'hA5, 8'hA5};
        vecs[1] = '{3'd1, 8'h3C, 8'h3C};
        vecs[2] = '{3'd2, 8'h0F, 8'h0F};
        vecs[3] = '{3'd3, 8'hF0, 8'hF0};
        vecs[4] = '{3'd4, 8'h81, 8'h81};
        vecs[5] = '{3'd5, 8'h7E, 8'h7E};
        vecs[6] = '{3'd7, 8'hFF, 8'h00};

        rst = 1'b1; cyc = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'h00;
        bus.cpu_ab = 16'hC000; bus.cpu_read = 1'b1; bus.cpu_db_out = 8'h00;
        repeat (3) tick();
        check("rst_cpu_rdy", 32'(bus.cpu_rdy), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_irq_n", 32'(irq_n), 32'(1));
        check("rst_mem_ab", 32'(bus.mem_ab), 32'h0000C000);
        check("rst_mem_read", 32'(bus.mem_read), 32'(1));
        check_reg("rst_status", 3'd7, 8'h00);
        check_reg("rst_src_l", 3'd0, 8'h00);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            cfg_write(vecs[i].addr, vecs[i].wdata);
            check_reg($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Copy of 3 bytes with irq enabled.
        setup(16'h1000, 16'h2000, 16'd3);
        push_copy(16'h1000, 16'h2000, 3);
        cfg_write(3'd6, 8'h05);
        check("copy_rdy_low", 32'(bus.cpu_rdy), 32'(0));
        check("copy_busy", 32'(busy), 32'(1));
        run_xfer("copy", n);
        check("copy_cycles", 32'(n), 32'(7));
        compare_bus("copy_bus");
        check("copy_irq_n", 32'(irq_n), 32'(0));
        check_reg("copy_status", 3'd7, 8'h40);
        cfg_write(3'd6, 8'h00);
        check("copy_irq_clr", 32'(irq_n), 32'(1));

        // Fill across the address wrap.
        setup(16'h1234, 16'hFFFE, 16'd4);
        exp_q.push_back({1'b1, 16'h1234, 8'h00});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 16'hFFFE + 16'(i), mem_f(16'h1234)});
        cfg_write(3'd6, 8'h03);
        run_xfer("fill", n);
        check("fill_cycles", 32'(n), 32'(6));
        compare_bus("fill_bus");
        check_reg("fill_status", 3'd7, 8'h40);
        check("fill_irq_n", 32'(irq_n), 32'(1));

        // 40-byte copy split into bursts of 16.
        setup(16'h3000, 16'h4000, 16'd40);
        push_copy(16'h3000, 16'h4000, 40);
        wbase = wr_count;
        gbase = gap_log.size();
        cfg_write(3'd6, 8'h01);
        run_xfer("burst", n);
        check("burst_cycles", 32'(n), 32'(85));
        compare_bus("burst_bus");
        check("burst_gaps", 32'(gap_log.size() - gbase), 32'(2));
        g0 = (gap_log.size() > gbase) ? gap_log[gbase] - wbase : -1;
        g1 = (gap_log.size() > gbase + 1) ? gap_log[gbase + 1] - wbase : -1;
        check("burst_gap0", 32'(g0), 32'(16));
        check("burst_gap1", 32'(g1), 32'(32));

        // CPU writing while in REQ: no DMA cycle, writes pass through.
        setup(16'h5000, 16'h6000, 16'd1);
        push_copy(16'h5000, 16'h6000, 1);
        bus.cpu_read = 1'b0; bus.cpu_ab = 16'h7777; bus.cpu_db_out = 8'hA5;
        cfg_write(3'd6, 8'h01);
        for (int k = 0; k < 3; k++) begin
            bus_cycle();
            check("stall_ab", 32'(bus.mem_ab), 32'h00007777);
            check("stall_read", 32'(bus.mem_read), 32'(0));
            check("stall_wdata", 32'(bus.mem_wdata), 32'h000000A5);
            check("stall_rdy", 32'(bus.cpu_rdy), 32'(0));
        end
        cfg_write(3'd0, 8'hFF);
        bus.cpu_read = 1'b1; bus.cpu_ab = 16'hC000;
        bus_cycle();
        check("stall_rd_ab", 32'(bus.mem_ab), 32'h00005000);
        check("stall_rd_read", 32'(bus.mem_read), 32'(1));
        run_xfer("stall", n);
        check("stall_cycles", 32'(n), 32'(2));
        compare_bus("stall_bus");

        // Zero length completes immediately.
        setup(16'h0100, 16'h0200, 16'd0);
        cfg_write(3'd6, 8'h01);
        check("len0_busy", 32'(busy), 32'(0));
        check("len0_rdy", 32'(bus.cpu_rdy), 32'(1));
        check_reg("len0_status", 3'd7, 8'h40);

        // Abort during RD of byte 5 of 10.
        setup(16'h7000, 16'h8000, 16'd10);
        push_copy(16'h7000, 16'h8000, 5);
        cfg_write(3'd6, 8'h01);
        repeat (9) bus_cycle();
        cfg_write(3'd6, 8'h08);
        run_xfer("abort", n);
        check("abort_cycles", 32'(n), 32'(2));
        compare_bus("abort_bus");
        check_reg("abort_status", 3'd7, 8'h40);
        check_reg("abort_dst_l", 3'd2, 8'h05);
        check_reg("abort_dst_h", 3'd3, 8'h80);

        // Reset in the middle of a WR.
        setup(16'h9000, 16'hA000, 16'd5);
        exp_q.push_back({1'b1, 16'h9000, 8'h00});
        cfg_write(3'd6, 8'h05);
        repeat (2) bus_cycle();
        check("rstwr_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        tick();
        check("rstwr_rdy", 32'(bus.cpu_rdy), 32'(1));
        check("rstwr_irq_n", 32'(irq_n), 32'(1));
        check_reg("rstwr_status", 3'd7, 8'h00);
        check_reg("rstwr_len_l", 3'd4, 8'h00);
        rst = 1'b0;
        tick();
        compare_bus("rstwr_bus");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
